// File: rtl/app_traffic_gen.sv
// rtl/app_traffic_gen.sv - multi-round write/read-back traffic generator for one Nanci node
module app_traffic_gen #(
    parameter int N              = 1024,
    parameter int I              = 0,
    parameter int DATA_WIDTH     = 32,
    parameter int MODE           = 0,
    parameter int STRIDE         = 1,
    parameter int ROUNDS         = 4,
    parameter int TIMEOUT        = 64,
    parameter int COMPUTE_CYCLES = 5,
    localparam int ADDR_WIDTH    = (N == 1024) ? 10 :
                                   (N == 256)  ? 8  :
                                   (N == 64)   ? 6  :
                                   (N == 16)   ? 4  : 2,
    localparam int WIDTH         = ADDR_WIDTH + DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             runnable,
    input  logic [WIDTH:0]   nanci_result,
    output logic [WIDTH:0]   app_request,
    output logic [13:0]      compute_cycles,
    output logic             done,
    output logic [7:0]       error_count
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_WRITE,
        S_READ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [WIDTH:0] NOP = {1'b0, ADDR_WIDTH'(I), DATA_WIDTH'(0)};

    state_t                  state;
    logic [7:0]              round;
    logic [CW-1:0]           wait_cnt;
    logic [CW-1:0]           cnt_next;
    logic [ADDR_WIDTH-1:0]   target;
    logic [DATA_WIDTH-1:0]   pattern;
    logic [7:0]              err_next;
    logic                    last_round;
    logic                    res_valid;
    logic [ADDR_WIDTH-1:0]   res_addr;
    logic [DATA_WIDTH-1:0]   res_data;
    logic                    hit;

    assign res_valid  = nanci_result[WIDTH];
    assign res_addr   = nanci_result[WIDTH-1:DATA_WIDTH];
    assign res_data   = nanci_result[DATA_WIDTH-1:0];
    assign hit        = res_valid && (res_addr == target);
    assign cnt_next   = wait_cnt + 1'b1;
    assign err_next   = (error_count == 8'hFF) ? error_count : error_count + 8'd1;
    assign last_round = (round == 8'(ROUNDS - 1));
    assign pattern    = DATA_WIDTH'((32'(round) << ADDR_WIDTH) | 32'(I));

    assign compute_cycles = 14'(COMPUTE_CYCLES);

    // Truncation to ADDR_WIDTH bits gives the modulo-N wrap since N is a power of two.
    always_comb begin
        target = ADDR_WIDTH'(I);
        case (MODE)
            0:       target = ADDR_WIDTH'(N - 1 - I);
            1:       target = ADDR_WIDTH'(I + STRIDE * (int'(round) + 1));
            2:       target = ADDR_WIDTH'(I + int'(round) + 1);
            default: target = ADDR_WIDTH'(I);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_WRITE;
            round       <= 8'd0;
            wait_cnt    <= '0;
            error_count <= 8'd0;
            done        <= 1'b0;
            app_request <= NOP;
        end else if (runnable) begin
            case (state)
                S_WRITE: begin
                    app_request <= {1'b1, target, pattern};
                    state       <= S_READ;
                end
                S_READ: begin
                    app_request <= {1'b0, target, DATA_WIDTH'(0)};
                    wait_cnt    <= '0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    app_request <= NOP;
                    // A matching result wins over a timeout landing on the same cycle.
                    if (hit || (cnt_next == CW'(TIMEOUT))) begin
                        if (!hit || (res_data != pattern)) begin
                            error_count <= err_next;
                        end
                        if (last_round) begin
                            state <= S_DONE;
                        end else begin
                            round <= round + 8'd1;
                            state <= S_WRITE;
                        end
                    end else begin
                        wait_cnt <= cnt_next;
                    end
                end
                default: begin
                    app_request <= NOP;
                    done        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/app_traffic_gen.md
Name: app_traffic_gen

Overview:
Parametrised per-node traffic-generating application for the Nanci network. It replaces the single fixed-pattern writer with a multi-round write/read-back engine. Each node writes a round-tagged pattern to a mode-selected target, reads it back through nanci_result, and counts mismatches and timeouts. The block plugs into the same application slot and uses the same app_request/nanci_result packing.

Parameters:
N, 1024, node count; power of two in {4,16,64,256,1024}.
I, 0, this node's index, 0..N-1.
DATA_WIDTH, 32, data field width.
MODE, 0, target pattern: 0=opposite (N-1-I), 1=stride, 2=rotate, 3=self.
STRIDE, 1, stride step for MODE=1.
ROUNDS, 4, write/read rounds; 1..255.
TIMEOUT, 64, max runnable cycles spent waiting for a read result; at least 1.
COMPUTE_CYCLES, 5, value driven on compute_cycles.
ADDR_WIDTH (derived), log2(N): 10/8/6/4/2 for N=1024/256/64/16/4; 2 otherwise.
WIDTH (derived), ADDR_WIDTH+DATA_WIDTH.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
runnable  in  1  application step enable; state advances only on cycles where it is high.
nanci_result  in  WIDTH+1  [WIDTH]=result valid, [WIDTH-1:DATA_WIDTH]=source address, [DATA_WIDTH-1:0]=read data.
app_request  out  WIDTH+1  registered; [WIDTH]=1 write / 0 read, [WIDTH-1:DATA_WIDTH]=address, [DATA_WIDTH-1:0]=data.
compute_cycles  out  14  constant COMPUTE_CYCLES.
done  out  1  high once all rounds have completed.
error_count  out  8  mismatches plus timeouts; saturates at 255.

Behaviour:
- Reset (sync, active-high, highest priority): state=WRITE, round r=0, wait counter=0, error_count=0, done=0, app_request=NOP.
- NOP encoding: {1'b0, I, DATA_WIDTH'b0}, a harmless read of the node's own address.
- Target address T(r), computed modulo N by truncation to ADDR_WIDTH bits:
  - MODE 0: N-1-I.
  - MODE 1: I+STRIDE*(r+1).
  - MODE 2: I+r+1.
  - MODE 3: I.
  - Every mode is a bijection across nodes, so each target is written by exactly one node per round.
- Pattern P(r) = (r << ADDR_WIDTH) | I, zero-extended or truncated to DATA_WIDTH.
- runnable low: all registers hold, including app_request.
- FSM (each transition happens only on a runnable cycle):
  - WRITE: app_request <= {1, T(r), P(r)}; next state READ.
  - READ: app_request <= {0, T(r), 0}; wait counter <= 0; next state WAIT.
  - WAIT: app_request <= NOP.
    - If nanci_result[WIDTH]=1 and its address field equals T(r): if the data field differs from P(r), error_count++ (saturating). Then advance.
    - Otherwise, wait counter++. When the counter reaches TIMEOUT, error_count++ (saturating) and advance.
    - A valid result whose address does not match T(r) is ignored and counts as a wait cycle.
  - Advance: if r==ROUNDS-1, go to DONE; else r++ and go to WRITE.
  - DONE: app_request <= NOP; done <= 1; absorbing state until reset.
- Latency: the write is visible on app_request the cycle after the first runnable following reset release. The read follows one runnable cycle after the write.
- Simultaneous events: a matching result on the same runnable cycle the counter would reach TIMEOUT is judged as a result; there is no timeout error for that round.
- Reset mid-operation: aborts the current round; no request is retained; the block restarts at round 0.
- nanci_result is sampled only in WAIT on runnable cycles; it is ignored in every other state.

Test Plan:
1. N=16, I=3, MODE=0, runnable tied high. Release reset → app_request={1,12,3}, then {0,12,0}. Drive nanci_result={1,12,3} → error_count=0 and the next request is {1,12,19}.
2. MODE=1, STRIDE=5, N=16, I=3. Round 2 write → address (3+15) mod 16=2, data 35.
3. In WAIT of round 0, drive result {1,12,7} → error_count=1. Drive valid result {1,5,3} (wrong address) → ignored; the round keeps waiting.
4. TIMEOUT=4 with no result → error_count increments on the 4th runnable WAIT cycle and the round advances. Toggling runnable low mid-wait stretches the timeout accordingly.
5. ROUNDS=2 with correct results → done=1 after the second WAIT. app_request stays {0,3,0} and done holds for more than 100 cycles.
6. Assert rst during WAIT of round 1 → the next cycle shows r=0, error_count=0, done=0, app_request=NOP. The first runnable after release reissues {1,12,3}.
